// File: rtl/sram_req_bridge.sv
// Single-outstanding valid/ready request bridge to a two-slave SRAM crossbar.
// Decodes slave windows, drives registered SRAM port signals, returns one response per request.
module sram_req_bridge #(
  parameter int unsigned        LEN_ADDR = 32,
  parameter int unsigned        LEN_DATA = 32,
  parameter logic [LEN_ADDR-1:0] S0_BASE = 32'h8000_0000,
  parameter logic [LEN_ADDR-1:0] S0_MASK = 32'hFFF0_0000,
  parameter logic [LEN_ADDR-1:0] S1_BASE = 32'h0000_0000,
  parameter logic [LEN_ADDR-1:0] S1_MASK = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_ADDR-1:0]   req_addr,
  input  logic [LEN_DATA-1:0]   req_wdata,
  input  logic [LEN_DATA/8-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LEN_DATA-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  sram_sel,
  output logic [LEN_ADDR-1:0]   sram_addr,
  output logic [LEN_DATA-1:0]   sram_wdata,
  output logic                  sram_ena,
  output logic [LEN_DATA/8-1:0] sram_wea,
  input  logic [LEN_DATA-1:0]   sram_rdata
);
  localparam int unsigned LEN_STRB = LEN_DATA / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state, w_state_next;
  logic                w_hit0, w_hit1, w_accept;
  logic                r_err, r_read, w_err_next, w_read_next;
  logic                r_sram_ena, w_sram_ena_next;
  logic [LEN_STRB-1:0] r_sram_wea, w_sram_wea_next;
  logic                r_sram_sel, w_sram_sel_next;
  logic [LEN_ADDR-1:0] r_sram_addr, w_sram_addr_next;
  logic [LEN_DATA-1:0] r_sram_wdata, w_sram_wdata_next;
  logic [LEN_DATA-1:0] r_resp_rdata, w_resp_rdata_next;
  logic                r_resp_err, w_resp_err_next;

  assign w_hit0    = (req_addr & S0_MASK) == S0_BASE;
  assign w_hit1    = (req_addr & S1_MASK) == S1_BASE;
  assign req_ready = (r_state == IDLE) || ((r_state == RESP) && resp_ready);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = ISSUE;
      ISSUE: w_state_next = WAIT;
      WAIT:  w_state_next = RESP;
      RESP:  if (resp_ready) w_state_next = w_accept ? ISSUE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // SRAM strobes are one-cycle pulses; address/data/select hold until the next accept.
  always_comb begin
    w_err_next        = r_err;
    w_read_next       = r_read;
    w_sram_ena_next   = 1'b0;
    w_sram_wea_next   = '0;
    w_sram_sel_next   = r_sram_sel;
    w_sram_addr_next  = r_sram_addr;
    w_sram_wdata_next = r_sram_wdata;
    w_resp_rdata_next = r_resp_rdata;
    w_resp_err_next   = r_resp_err;
    if (w_accept) begin
      w_err_next        = !(w_hit0 || w_hit1);
      w_read_next       = (req_wstrb == '0);
      w_sram_ena_next   = w_hit0 || w_hit1;
      w_sram_wea_next   = (w_hit0 || w_hit1) ? req_wstrb : '0;
      w_sram_sel_next   = !w_hit0;
      w_sram_addr_next  = req_addr;
      w_sram_wdata_next = req_wdata;
    end
    if (r_state == WAIT) begin
      w_resp_rdata_next = (r_read && !r_err) ? sram_rdata : '0;
      w_resp_err_next   = r_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= 1'b0;
      r_read       <= 1'b0;
      r_sram_ena   <= 1'b0;
      r_sram_wea   <= '0;
      r_sram_sel   <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_err        <= w_err_next;
      r_read       <= w_read_next;
      r_sram_ena   <= w_sram_ena_next;
      r_sram_wea   <= w_sram_wea_next;
      r_sram_sel   <= w_sram_sel_next;
      r_sram_addr  <= w_sram_addr_next;
      r_sram_wdata <= w_sram_wdata_next;
      r_resp_rdata <= w_resp_rdata_next;
      r_resp_err   <= w_resp_err_next;
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign sram_ena   = r_sram_ena;
  assign sram_wea   = r_sram_wea;
  assign sram_sel   = r_sram_sel;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge with a two-slave, one-cycle-latency SRAM model behind a mux.
module tb_sram_req_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        sram_sel;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ena;
  logic [3:0]  sram_wea;
  logic [31:0] sram_rdata;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] dout0 = '0;
  logic [31:0] dout1 = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  sram_req_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .sram_sel(sram_sel), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Crossbar + two read-first BRAMs: ena/wea steered by sel, douta muxed back by sel.
  always @(posedge clk) begin
    if (sram_ena) begin
      if (sram_sel) begin
        dout1 <= mem1[sram_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (sram_wea[b]) mem1[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        dout0 <= mem0[sram_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (sram_wea[b]) mem0[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end
  assign sram_rdata = sram_sel ? dout1 : dout0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  // Drives one request from IDLE and walks it through ISSUE/WAIT/RESP; leaves it in RESP
  // with resp_ready low when hold is set, otherwise completes the handshake.
  task automatic run_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic exp_ena, input logic exp_sel,
                         input logic check_sel, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic hold);
    @(negedge clk);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_issue_ena"}, {31'd0, sram_ena}, {31'd0, exp_ena});
    check({tag, "_issue_wea"}, {28'd0, sram_wea}, exp_ena ? {28'd0, wstrb} : 32'd0);
    if (exp_ena) check({tag, "_issue_addr"}, sram_addr, addr);
    if (check_sel) check({tag, "_issue_sel"}, {31'd0, sram_sel}, {31'd0, exp_sel});
    check({tag, "_issue_rv"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_wait_ena"}, {31'd0, sram_ena}, 32'd0);
    if (check_sel) check({tag, "_wait_sel"}, {31'd0, sram_sel}, {31'd0, exp_sel});
    check({tag, "_wait_rv"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    if (!hold) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "_idle_rv"}, {31'd0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[16] = 32'h1111_1111;
    mem1[16] = 32'h2222_2222;

    #12;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_sram_ena", {31'd0, sram_ena}, 32'd0);
    check("rst_sram_sel", {31'd0, sram_sel}, 32'd0);
    check("rst_sram_addr", sram_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req("t1_wr", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    run_req("t2_rd", 32'h8000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_req("t3_rd_s1", 32'h0000_0040, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    run_req("t4_unmap", 32'h4000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: response held, next request waiting.
    run_req("t5_rd", 32'h0000_0040, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 1'b0, 1'b1);
    req_valid = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h1234_5678; req_wstrb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("t5_stall_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("t5_stall_rdata", resp_rdata, 32'h2222_2222);
    end
    resp_ready = 1'b1;
    #1 check("t5_ready_comb", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b0;
    check("t5_b2b_issue_ena", {31'd0, sram_ena}, 32'd1);
    check("t5_b2b_issue_wea", {28'd0, sram_wea}, 32'h3);
    check("t5_b2b_issue_addr", sram_addr, 32'h8000_0020);
    check("t5_b2b_issue_rv", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("t5_b2b_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t5_b2b_resp_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    run_req("t5_rdback", 32'h8000_0020, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_5678, 1'b0, 1'b0);

    // Reset during WAIT of a slave1 read.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_0040; req_wstrb = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("t6_wait_sel", {31'd0, sram_sel}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("t6_rst_sram_ena", {31'd0, sram_ena}, 32'd0);
    check("t6_rst_sram_sel", {31'd0, sram_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_post_req_ready", {31'd0, req_ready}, 32'd1);
      check("t6_post_resp_valid", {31'd0, resp_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
